// File: rtl/uart2i2c_pkg.sv
// rtl/uart2i2c_pkg.sv - shared constants, state and error encodings for the UART2I2C bridge
package uart2i2c_pkg;

    localparam logic [7:0] HDR0       = 8'h55;
    localparam logic [7:0] HDR1       = 8'hA5;
    localparam int         MAX_BYTES  = 16;
    localparam int         CMD_RD_BIT = 7;

    typedef enum logic [2:0] {
        S_H0,
        S_H1,
        S_CMD,
        S_AH,
        S_AL,
        S_DATA,
        S_ISSUE
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_BUSY    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    function automatic logic len_ok(input logic [6:0] n);
        return (n != 7'd0) && (n <= 7'(MAX_BYTES));
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - byte stream in, EEPROM command out
interface uart_cmd_parser_if;
    logic [7:0]   rx_data;
    logic         rx_done;
    logic         cmd_ready;
    logic [15:0]  address;
    logic [127:0] cmd_data;
    logic [7:0]   num_cmd;
    logic         cmdvalid;
    logic         frame_err;
    logic [1:0]   err_code;

    modport master (
        input  rx_data, rx_done, cmd_ready,
        output address, cmd_data, num_cmd, cmdvalid, frame_err, err_code
    );

    modport slave (
        output rx_data, rx_done, cmd_ready,
        input  address, cmd_data, num_cmd, cmdvalid, frame_err, err_code
    );
endinterface

// File: rtl/uart_cmd_parser_timer.sv
// rtl/uart_cmd_parser_timer.sv - inter-byte timeout counter
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk50M,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    assign expired = enable && (count == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - header hunt and frame assembly into one EEPROM command
module uart_cmd_parser
    import uart2i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk50M,
    input  logic                  rst_n,
    uart_cmd_parser_if.master     bus
);
    state_t         state, state_n;
    logic [7:0]     wcmd;
    logic [15:0]    waddr;
    logic [127:0]   wdata;
    logic [4:0]     byte_cnt;
    logic           tmr_en, tmr_clr, expired;
    logic           timeout, len_err, last_byte;

    logic [15:0]    address_q;
    logic [127:0]   cmd_data_q;
    logic [7:0]     num_cmd_q;
    logic           cmdvalid_q, frame_err_q;
    logic [1:0]     err_code_q;

    assign tmr_en  = (state != S_H0) && (state != S_ISSUE);
    assign tmr_clr = bus.rx_done || !tmr_en;

    frame_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk50M  (clk50M),
        .rst_n   (rst_n),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .expired (expired)
    );

    assign last_byte = (byte_cnt == 5'(wcmd[6:0] - 7'd1));

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) state <= S_H0;
        else        state <= state_n;
    end

    // Timeout outranks any byte arriving in the same cycle.
    always_comb begin
        state_n = state;
        timeout = 1'b0;
        len_err = 1'b0;
        if (expired) begin
            timeout = 1'b1;
            state_n = S_H0;
        end else begin
            case (state)
                S_H0:    if (bus.rx_done && bus.rx_data == HDR0) state_n = S_H1;
                S_H1:    if (bus.rx_done) begin
                             if (bus.rx_data == HDR1)      state_n = S_CMD;
                             else if (bus.rx_data != HDR0) state_n = S_H0;
                         end
                S_CMD:   if (bus.rx_done) begin
                             if (!len_ok(bus.rx_data[6:0])) begin
                                 len_err = 1'b1;
                                 state_n = S_H0;
                             end else begin
                                 state_n = S_AH;
                             end
                         end
                S_AH:    if (bus.rx_done) state_n = S_AL;
                S_AL:    if (bus.rx_done) state_n = wcmd[CMD_RD_BIT] ? S_ISSUE : S_DATA;
                S_DATA:  if (bus.rx_done && last_byte) state_n = S_ISSUE;
                S_ISSUE: state_n = S_H0;
                default: state_n = S_H0;
            endcase
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            wcmd        <= '0;
            waddr       <= '0;
            wdata       <= '0;
            byte_cnt    <= '0;
            address_q   <= '0;
            cmd_data_q  <= '0;
            num_cmd_q   <= '0;
            cmdvalid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            cmdvalid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (timeout) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
            end else begin
                case (state)
                    S_CMD: if (bus.rx_done) begin
                        wcmd <= bus.rx_data;
                        if (len_err) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                        end else begin
                            wdata <= '0;
                        end
                    end
                    S_AH: if (bus.rx_done) waddr[15:8] <= bus.rx_data;
                    S_AL: if (bus.rx_done) begin
                        waddr[7:0] <= bus.rx_data;
                        byte_cnt   <= '0;
                    end
                    S_DATA: if (bus.rx_done) begin
                        wdata[8*(MAX_BYTES-1-int'(byte_cnt)) +: 8] <= bus.rx_data;
                        byte_cnt <= byte_cnt + 5'd1;
                    end
                    S_ISSUE: begin
                        if (bus.cmd_ready) begin
                            address_q  <= waddr;
                            cmd_data_q <= wdata;
                            num_cmd_q  <= wcmd;
                            cmdvalid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_BUSY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.address   = address_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.num_cmd   = num_cmd_q;
    assign bus.cmdvalid  = cmdvalid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed and random frames against a frame-level reference model
module tb_uart_cmd_parser;
    localparam int T = 40;

    logic clk50M = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
        .clk50M (clk50M),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 clk50M = ~clk50M;

    // Frame-level reference: header tracking, collected frame bytes, pending issue.
    logic          m_hdr, m_in, m_issue;
    logic [7:0]    m_buf[$];
    longint        cyc, m_last;
    logic [15:0]   e_addr;
    logic [127:0]  e_data;
    logic [7:0]    e_num;
    logic          e_valid, e_err;
    logic [1:0]    e_code;

    function automatic void model_reset();
        m_hdr = 0; m_in = 0; m_issue = 0; m_buf = {};
        cyc = 0; m_last = 0;
        e_addr = '0; e_data = '0; e_num = '0;
        e_valid = 0; e_err = 0; e_code = 2'd0;
    endfunction

    function automatic void model_step(input logic rd, input logic [7:0] b, input logic rdy);
        int n;
        logic [7:0] c;
        cyc++;
        e_valid = 0;
        e_err   = 0;
        if (m_issue) begin
            m_issue = 0;
            if (rdy) begin
                c = m_buf[0];
                n = int'(c[6:0]);
                e_addr = {m_buf[1], m_buf[2]};
                e_num  = c;
                e_data = '0;
                if (!c[7])
                    for (int k = 0; k < n; k++) e_data[127-8*k -: 8] = m_buf[3+k];
                e_valid = 1;
            end else begin
                e_err = 1; e_code = 2'd2;
            end
        end else if ((m_hdr || m_in) && (cyc - m_last >= T)) begin
            e_err = 1; e_code = 2'd3;
            m_hdr = 0; m_in = 0;
        end else if (rd) begin
            m_last = cyc;
            if (m_in) begin
                m_buf.push_back(b);
                c = m_buf[0];
                n = int'(c[6:0]);
                if (m_buf.size() == 1 && (n == 0 || n > 16)) begin
                    e_err = 1; e_code = 2'd1; m_in = 0;
                end else if ((m_buf.size() == 3 && c[7]) ||
                             (!c[7] && m_buf.size() == 3 + n)) begin
                    m_issue = 1; m_in = 0;
                end
            end else if (m_hdr && b == 8'hA5) begin
                m_in = 1; m_hdr = 0; m_buf = {};
            end else begin
                m_hdr = (b == 8'h55);
            end
        end
    endfunction

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk50M) begin
        if (rst_n === 1'b1) begin
            model_step(bus.rx_done, bus.rx_data, bus.cmd_ready);
            #1;
            check("cmdvalid",  bus.cmdvalid,  e_valid);
            check("frame_err", bus.frame_err, e_err);
            check("err_code",  bus.err_code,  e_code);
            check("address",   bus.address,   e_addr);
            check("num_cmd",   bus.num_cmd,   e_num);
            check("cmd_data",  bus.cmd_data,  e_data);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk50M);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk50M);
        bus.rx_done = 1'b0;
        bus.rx_data = 8'($urandom);
        repeat (gap) @(negedge clk50M);
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int gap);
        foreach (fr[i]) send_byte(fr[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk50M);
    endtask

    task automatic random_frame();
        logic [7:0] fr[$];
        int kind, n;
        logic rd;
        kind = $urandom_range(0, 99);
        bus.cmd_ready = ($urandom_range(0, 4) != 0);
        fr = {8'h55, 8'hA5};
        if (kind < 60) begin
            n  = $urandom_range(1, 16);
            rd = $urandom_range(0, 1);
            fr.push_back({rd, 7'(n)});
            fr.push_back(8'($urandom));
            fr.push_back(8'($urandom));
            if (!rd) for (int k = 0; k < n; k++) fr.push_back(8'($urandom));
        end else if (kind < 75) begin
            fr.push_back({1'($urandom), ($urandom_range(0, 1) != 0) ? 7'd0 : 7'($urandom_range(17, 127))});
        end else if (kind < 90) begin
            fr = {};
            for (int k = 0; k < $urandom_range(1, 8); k++)
                fr.push_back(($urandom_range(0, 2) == 0) ? 8'h55 : 8'($urandom));
        end else begin
            fr.push_back(8'($urandom_range(1, 16)));
            fr.push_back(8'($urandom));
        end
        foreach (fr[i]) send_byte(fr[i], $urandom_range(0, 2));
        idle((kind >= 90) ? T + 3 : $urandom_range(1, 3));
    endtask

    initial begin
        model_reset();
        rst_n         = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_done   = 1'b0;
        bus.cmd_ready = 1'b1;
        idle(3);
        check("reset_address",  bus.address,  16'h0);
        check("reset_cmd_data", bus.cmd_data, 128'h0);
        check("reset_num_cmd",  bus.num_cmd,  8'h0);
        check("reset_err_code", bus.err_code, 2'd0);
        rst_n = 1'b1;
        idle(2);

        send_frame({8'h55, 8'hA5, 8'h03, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33}, 0);
        idle(3);
        check("wr3_address",  bus.address,  16'h0010);
        check("wr3_num_cmd",  bus.num_cmd,  8'h03);
        check("wr3_cmd_data", bus.cmd_data, {24'h112233, 104'h0});

        send_frame({8'h55, 8'hA5, 8'h90, 8'h12}, 1);
        send_byte(8'h34, 0);
        check("rd_latency_edge1", bus.cmdvalid, 1'b0);
        idle(1);
        check("rd_latency_edge2", bus.cmdvalid, 1'b1);
        idle(2);
        check("rd16_address",  bus.address,  16'h1234);
        check("rd16_num_cmd",  bus.num_cmd,  8'h90);
        check("rd16_cmd_data", bus.cmd_data, 128'h0);

        send_frame({8'h00, 8'h55, 8'h55, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h7E}, 0);
        idle(3);
        check("resync_address",  bus.address,  16'h0000);
        check("resync_num_cmd",  bus.num_cmd,  8'h01);
        check("resync_cmd_data", bus.cmd_data, {8'h7E, 120'h0});

        send_frame({8'h55, 8'hA5, 8'h11}, 0);
        idle(2);
        check("len_err_code", bus.err_code, 2'd1);
        check("len_keep_num", bus.num_cmd,  8'h01);
        send_frame({8'h55, 8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h01, 8'h02}, 1);
        idle(3);
        check("after_len_address", bus.address,  16'hABCD);
        check("after_len_data",    bus.cmd_data, {16'h0102, 112'h0});

        bus.cmd_ready = 1'b0;
        send_frame({8'h55, 8'hA5, 8'h01, 8'h00, 8'h05, 8'h99}, 0);
        idle(3);
        check("busy_err_code",     bus.err_code, 2'd2);
        check("busy_keep_address", bus.address,  16'hABCD);
        check("busy_keep_num",     bus.num_cmd,  8'h02);
        bus.cmd_ready = 1'b1;

        send_frame({8'h55, 8'hA5, 8'h02, 8'h00}, 0);
        idle(T + 5);
        check("timeout_err_code", bus.err_code, 2'd3);

        send_frame({8'h55, 8'hA5, 8'h04, 8'h00}, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_address",  bus.address,  16'h0);
        check("midrst_cmd_data", bus.cmd_data, 128'h0);
        check("midrst_num_cmd",  bus.num_cmd,  8'h0);
        check("midrst_err_code", bus.err_code, 2'd0);
        idle(2);
        rst_n = 1'b1;
        send_frame({8'h55, 8'hA5, 8'h81, 8'h00, 8'h07}, 0);
        idle(3);
        check("postrst_address", bus.address, 16'h0007);
        check("postrst_num_cmd", bus.num_cmd, 8'h81);

        for (int i = 0; i < 300; i++) random_frame();
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Upstream stage of the UART2I2C EEPROM bridge: turns the byte stream from the UART receiver into one complete EEPROM command.
- Hunts for a 2-byte header, then collects the command byte, the 16-bit start address and, for writes only, up to 16 payload bytes.
- Publishes address, cmd_data, num_cmd and a single-cycle cmdvalid to the EEPROM command converter.
- Assembles each frame in a working buffer; output registers change only when a frame is accepted, so they stay stable while the converter walks them.

Parameters:
- HDR0, 8'h55, first header byte
- HDR1, 8'hA5, second header byte
- TIMEOUT_CYCLES, 500000, maximum clk50M cycles between bytes inside a frame (10 ms at 50 MHz)
- MAX_BYTES, 16, maximum payload byte count

Ports:
- clk50M  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received UART byte, valid while rx_done=1
- rx_done  in  1  one-cycle strobe, one byte received
- cmd_ready  in  1  converter idle and able to accept a command
- address  out  16  EEPROM start address
- cmd_data  out  128  payload; byte k at [127-8k -: 8]
- num_cmd  out  8  bit7=1 read, bit7=0 write; [6:0] byte count 1..16
- cmdvalid  out  1  one-cycle pulse, new command on outputs
- frame_err  out  1  one-cycle pulse, frame dropped
- err_code  out  2  cause of last drop; held until the next drop

Behaviour:
- Clock and reset: one clock, clk50M; reset is asynchronous and active-low (rst_n). All outputs, the working buffer, the timer and the state machine are cleared to 0 / S_H0 at reset.
- Frame format: HDR0, HDR1, CMD, ADDR_H, ADDR_L, then DATA0..DATA(n-1) for writes only, where n = CMD[6:0]. Reads carry no payload.
- Byte acceptance: a byte is consumed only in a cycle where rx_done=1; rx_data is ignored otherwise.
- State machine (all transitions are on rx_done unless noted):
  - S_H0: byte == HDR0 -> S_H1; any other byte stays in S_H0.
  - S_H1: byte == HDR1 -> S_CMD; byte == HDR0 stays in S_H1 (resync); any other byte -> S_H0.
  - S_CMD: latch CMD.
    - If CMD[6:0] == 0 or > MAX_BYTES: pulse frame_err, set err_code=2'd1, go to S_H0.
    - Otherwise clear the working data buffer to 0 and go to S_AH.
  - S_AH: latch the high address byte, then S_AL.
  - S_AL: latch the low address byte. For a read (CMD[7]=1) go to S_ISSUE; for a write, clear byte_cnt and go to S_DATA.
  - S_DATA: store the byte at working index byte_cnt and increment byte_cnt (5 bits). When byte_cnt reaches n-1 on this byte, go to S_ISSUE.
  - S_ISSUE (exactly one cycle, no rx_done needed):
    - If cmd_ready=1: copy the working address/data/CMD to the outputs, pulse cmdvalid, go to S_H0.
    - If cmd_ready=0: outputs are unchanged, pulse frame_err, set err_code=2'd2, go to S_H0.
- Latency: cmdvalid rises on the second clock edge after the rx_done of the last byte (one edge to enter S_ISSUE, one to issue).
- Unused payload bytes: output bytes at index >= n are 0. For reads the whole cmd_data output is 0.
- Inter-byte timeout:
  - The timer resets on every rx_done and counts in every state other than S_H0 and S_ISSUE.
  - When it reaches TIMEOUT_CYCLES-1: pulse frame_err, set err_code=2'd3, go to S_H0, discard the partial frame.
  - If rx_done arrives in that same cycle, the timeout wins and the byte is discarded.
- Simultaneous events: a byte that arrives while in S_ISSUE is ignored; the host must not stream back-to-back frames closer than one cycle apart.
- Reset mid-frame: the partial frame is lost and the outputs return to 0 immediately.
- Error signalling: cmdvalid and frame_err are never asserted in the same cycle. err_code=2'd0 only after reset.

Decomposition:
- Shared package uart2i2c_pkg holds:
  - header constants;
  - state encodings;
  - err_code values: ERR_NONE=0, ERR_LEN=1, ERR_BUSY=2, ERR_TIMEOUT=3;
  - CMD_RD_BIT=7.
- One natural sub-module, frame_timeout_timer: a loadable counter with inputs clear and enable and a single expired output. Everything else stays in one always block.

Test Plan:
- Write, 3 bytes: send 55 A5 03 00 10 11 22 33 with cmd_ready=1 -> one cmdvalid pulse; address=16'h0010, num_cmd=8'h03, cmd_data[127:104]=24'h112233, cmd_data[103:0]=0.
- Read, 16 bytes: send 55 A5 90 12 34 -> cmdvalid two edges after the last byte; num_cmd=8'h90, address=16'h1234, cmd_data=0, no payload bytes consumed.
- Resync and garbage: send 00 55 55 A5 01 00 00 7E -> cmdvalid; address=0, num_cmd=8'h01, cmd_data[127:120]=8'h7E.
- Length error: send 55 A5 11 ... -> frame_err pulse, err_code=1, no cmdvalid. A valid frame sent next is accepted.
- Busy drop: a valid write frame completes with cmd_ready=0 -> frame_err, err_code=2, and the outputs keep the previous command's values.
- Timeout and reset: send 55 A5 02 00 then idle for TIMEOUT_CYCLES -> frame_err, err_code=3. Separately, assert rst_n=0 mid-frame -> all outputs 0, and the next full frame parses correctly.
